multi_threshold: RTL

MULTI_THRESHOLD -- requirements
Module: multi_threshold

---
 rtl/multi_threshold_if.sv | 35 +++
 rtl/multi_threshold.sv | 117 +++++++++++
 2 files changed

// File: rtl/multi_threshold_if.sv
// multi_threshold_if: sample, configuration and result bus of multi_threshold
// Signals:
//   cntr/cntr_valid        - per-channel samples and their strobes
//   cfg_high/low/hold/load - threshold and hold-off configuration with load strobe
//   first_clr              - clears the first-arrival latch
//   detect/ch_state        - per-channel detection pulse and FSM state
//   first_valid/first_ch   - first-arrival latch
//   cfg_err                - loaded thresholds are invalid
// Modports: master drives samples/config, slave is the detector.
interface multi_threshold_if #(
    parameter int CNTR_WIDTH = 10,
    parameter int CHANNELS   = 4,
    parameter int HOLD_WIDTH = 8
);
    logic [CHANNELS*CNTR_WIDTH-1:0] cntr;
    logic [CHANNELS-1:0]            cntr_valid;
    logic [CNTR_WIDTH-1:0]          cfg_high;
    logic [CNTR_WIDTH-1:0]          cfg_low;
    logic [HOLD_WIDTH-1:0]          cfg_hold;
    logic                           cfg_load;
    logic                           first_clr;
    logic [CHANNELS-1:0]            detect;
    logic [2*CHANNELS-1:0]          ch_state;
    logic                           first_valid;
    logic [3:0]                     first_ch;
    logic                           cfg_err;
    modport master (
        output cntr, cntr_valid, cfg_high, cfg_low, cfg_hold, cfg_load, first_clr,
        input  detect, ch_state, first_valid, first_ch, cfg_err
    );
    modport slave (
        input  cntr, cntr_valid, cfg_high, cfg_low, cfg_hold, cfg_load, first_clr,
        output detect, ch_state, first_valid, first_ch, cfg_err
    );
endinterface

// File: rtl/multi_threshold.sv
// multi_threshold: per-channel hysteresis threshold detector with hold-off and first-arrival latch
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-low reset
//   bus - multi_threshold_if.slave: samples, config, detect pulses, channel states,
//         first-arrival result and cfg_err
module multi_threshold #(
    parameter int CNTR_WIDTH = 10,
    parameter int CHANNELS   = 4,
    parameter int HOLD_WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    multi_threshold_if.slave bus
);
    localparam logic [1:0] LOW = 2'b00, HIGH = 2'b01, HOLD = 2'b10;
    // Reset thresholds saturate when 800/400 do not fit the sample width
    localparam logic [CNTR_WIDTH-1:0] DEF_HIGH = CNTR_WIDTH >= 10 ? CNTR_WIDTH'(800) : {CNTR_WIDTH{1'b1}};
    localparam logic [CNTR_WIDTH-1:0] DEF_LOW  = CNTR_WIDTH >= 9  ? CNTR_WIDTH'(400) : {CNTR_WIDTH{1'b1}};

    logic [CNTR_WIDTH-1:0] high_q, low_q;
    logic [HOLD_WIDTH-1:0] hold_q;
    logic                  err_q;
    logic [1:0]            state_q [CHANNELS];
    logic [1:0]            state_d [CHANNELS];
    logic [HOLD_WIDTH-1:0] cnt_q   [CHANNELS];
    logic [HOLD_WIDTH-1:0] cnt_d   [CHANNELS];
    logic [CHANNELS-1:0]   det_q, det_d;
    logic                  fv_q;
    logic [3:0]            fc_q, fc_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            high_q <= DEF_HIGH;
            low_q  <= DEF_LOW;
            hold_q <= '0;
            err_q  <= 1'b0;
        end else if (bus.cfg_load) begin
            high_q <= bus.cfg_high;
            low_q  <= bus.cfg_low;
            hold_q <= bus.cfg_hold;
            err_q  <= bus.cfg_high <= bus.cfg_low;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= LOW;
                cnt_q[i]   <= '0;
            end
            det_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            det_q <= det_d;
        end
    end

    // A config error freezes every channel, hold counters included
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            det_d[i]   = 1'b0;
            if (state_q[i] == 2'b11) begin
                state_d[i] = LOW;
                cnt_d[i]   = '0;
            end else if (!err_q) begin
                case (state_q[i])
                    LOW: if (bus.cntr_valid[i] && bus.cntr[i*CNTR_WIDTH +: CNTR_WIDTH] >= high_q) begin
                        state_d[i] = HIGH;
                        det_d[i]   = 1'b1;
                    end
                    HIGH: if (bus.cntr_valid[i] && bus.cntr[i*CNTR_WIDTH +: CNTR_WIDTH] <= low_q) begin
                        state_d[i] = hold_q == '0 ? LOW : HOLD;
                        cnt_d[i]   = hold_q;
                    end
                    default: begin
                        cnt_d[i]   = cnt_q[i] <= HOLD_WIDTH'(1) ? '0 : cnt_q[i] - 1'b1;
                        state_d[i] = cnt_q[i] <= HOLD_WIDTH'(1) ? LOW : HOLD;
                    end
                endcase
            end
        end
    end

    // Lowest detecting index wins: scan downward so the last hit is the smallest
    always_comb begin
        fc_d = '0;
        for (int i = CHANNELS - 1; i >= 0; i--)
            if (det_d[i]) fc_d = 4'(i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fv_q <= 1'b0;
            fc_q <= '0;
        end else if (|det_d && (!fv_q || bus.first_clr)) begin
            fv_q <= 1'b1;
            fc_q <= fc_d;
        end else if (bus.first_clr) begin
            fv_q <= 1'b0;
        end
    end

    always_comb begin
        bus.ch_state = '0;
        for (int i = 0; i < CHANNELS; i++) bus.ch_state[2*i +: 2] = state_q[i];
        bus.detect      = det_q;
        bus.first_valid = fv_q;
        bus.first_ch    = fc_q;
        bus.cfg_err     = err_q;
    end
endmodule
